// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD display arbiter.
//   SEG_0..SEG_9, SEG_BLANK : active-low 7-segment codes, bit order {a,b,c,d,e,f,g}
//   state_t                 : arbiter/converter FSM states
//   add3()                  : shift-add-3 correction for one BCD nibble
package bcd_disp_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int MAX_VAL_DEF   = 200;
    localparam int BLANK_VAL_DEF = 200;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD
    } state_t;

    // Nibbles >= 5 would exceed 9 after the next doubling, so pre-correct them.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational BCD digit to 7-segment decoder.
//   i_bcd : 4-bit BCD digit (values 10..15 decode to blank)
//   o_seg : active-low segments {a,b,c,d,e,f,g}
module seg7_digit
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_arbiter.sv
// Shares one 3-digit 7-segment display between two requesters.
// Round-robin arbitration, serial shift-add-3 binary-to-BCD conversion
// (one bit per clock), registered segment drive.
//   clk, rst          : clock (rising edge), async active-high reset
//   req_a/data_a/gnt_a: requester A request, value, 1-cycle capture pulse
//   req_b/data_b/gnt_b: requester B, same rules
//   busy              : FSM not idle
//   done              : 1-cycle pulse, new CEN/DEZ/UNI valid
//   err               : 1-cycle pulse, captured value above MAX_VAL was rejected
//   src               : owner of the displayed value (0=A, 1=B)
//   CEN/DEZ/UNI       : hundreds/tens/units digits, active-low segments
module bcd_display_arbiter
    import bcd_disp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_VAL   = MAX_VAL_DEF,
    parameter int BLANK_VAL = BLANK_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             src,
    output logic [6:0]       CEN,
    output logic [6:0]       DEZ,
    output logic [6:0]       UNI
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_rr_ptr;     // 0 = A wins a tie, 1 = B wins a tie
    logic              r_winner;
    logic              r_blank;
    logic              r_rej_pend;
    logic [WIDTH-1:0]  r_bin;
    logic [11:0]       r_bcd;
    logic [CW-1:0]     r_cnt;
    logic              r_gnt_a, r_gnt_b, r_done, r_err, r_src;
    logic [6:0]        r_cen, r_dez, r_uni;

    logic              w_req_any;
    logic              w_sel_b;
    logic [WIDTH-1:0]  w_win_data;
    logic              w_reject;
    logic              w_blank;
    logic              w_accept;
    logic [11:0]       w_bcd_adj;
    logic [6:0]        w_seg_c, w_seg_d, w_seg_u;

    assign w_req_any  = req_a | req_b;
    assign w_sel_b    = (req_a & req_b) ? r_rr_ptr : req_b;
    assign w_win_data = w_sel_b ? data_b : data_a;
    assign w_reject   = int'(w_win_data) > MAX_VAL;
    assign w_blank    = int'(w_win_data) == BLANK_VAL;
    // A rejected capture reports err one cycle after its grant; requests are
    // not sampled in that cycle so gnt and err never overlap and the
    // requester has time to drop its req.
    assign w_accept   = (r_state == ST_IDLE) && w_req_any && !r_rej_pend;
    assign w_bcd_adj  = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

    seg7_digit u_seg_c (.i_bcd(r_bcd[11:8]), .o_seg(w_seg_c));
    seg7_digit u_seg_d (.i_bcd(r_bcd[7:4]),  .o_seg(w_seg_d));
    seg7_digit u_seg_u (.i_bcd(r_bcd[3:0]),  .o_seg(w_seg_u));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this purely combinational;
    // a path that leaves w_next unassigned would infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_reject) w_next = w_blank ? ST_LOAD : ST_CONV;
            ST_CONV: if (r_cnt == '0) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Datapath: capture, conversion, display registers and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= 1'b0;
            r_winner   <= 1'b0;
            r_blank    <= 1'b0;
            r_rej_pend <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_src      <= 1'b0;
            r_cen      <= SEG_BLANK;
            r_dez      <= SEG_BLANK;
            r_uni      <= SEG_BLANK;
        end else begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= r_rej_pend;
            r_rej_pend <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt_a    <= ~w_sel_b;
                        r_gnt_b    <= w_sel_b;
                        // Only contention moves the pointer, toward the loser.
                        if (req_a && req_b) r_rr_ptr <= ~w_sel_b;
                        r_winner   <= w_sel_b;
                        r_bin      <= w_win_data;
                        r_bcd      <= '0;
                        r_cnt      <= CW'(WIDTH - 1);
                        r_blank    <= w_blank;
                        r_rej_pend <= w_reject;
                    end
                end
                ST_CONV: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                ST_LOAD: begin
                    r_cen  <= r_blank ? SEG_BLANK : w_seg_c;
                    r_dez  <= r_blank ? SEG_BLANK : w_seg_d;
                    r_uni  <= r_blank ? SEG_BLANK : w_seg_u;
                    r_src  <= r_winner;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt_a = r_gnt_a;
    assign gnt_b = r_gnt_b;
    assign done  = r_done;
    assign err   = r_err;
    assign src   = r_src;
    assign CEN   = r_cen;
    assign DEZ   = r_dez;
    assign UNI   = r_uni;

endmodule
